// File: rtl/csi_crc16_tx_append_if.sv
// Byte-stream handshake bundle between the payload source, the CRC
// append stage and the lane distributor.
interface csi_crc16_tx_append_if;
    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       s_last_i;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_last_o;
    logic       m_ready_i;

    // CRC append stage: consumes the payload stream, produces payload + footer
    modport slave (
        input  s_data_i,
        input  s_valid_i,
        input  s_last_i,
        output s_ready_o,
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    // Surrounding logic: drives payload in, drains the output stream
    modport master (
        output s_data_i,
        output s_valid_i,
        output s_last_i,
        input  s_ready_o,
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/csi_crc16_tx_append.sv
// CSI-2 transmit CRC append: forwards the payload bytes unchanged and
// follows each packet with its CRC-16 footer (low byte, then high byte).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_PAYLOAD  | accepting payload bytes, CRC accumulates per accepted byte
// ST_CRC_LO   | payload closed, waiting to load CRC low byte into output
// ST_CRC_HI   | waiting to load CRC high byte (with last), then reseed CRC
module csi_crc16_tx_append #(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    csi_crc16_tx_append_if.slave        bus,
    output logic [15:0]                 crc_o
);

    typedef enum logic [1:0] {
        ST_PAYLOAD = 2'd0,
        ST_CRC_LO  = 2'd1,
        ST_CRC_HI  = 2'd2
    } state_t;

    // Reflected CRC-16 (poly 0x8408), eight bit-steps, data LSB first
    function automatic logic [15:0] crc_step8(input logic [15:0] crc_in,
                                              input logic [7:0]  data_in);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data_in[i];
            c  = (c >> 1) ^ (fb ? 16'h8408 : 16'h0000);
        end
        return c;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic [15:0] r_crc;

    logic        w_out_free;
    logic        w_s_ready;
    logic        w_s_accept;
    logic        w_load;
    logic [7:0]  w_load_data;
    logic        w_load_last;
    logic [15:0] w_crc_next;

    // The single output register can take a new byte if empty or draining now
    assign w_out_free = !r_m_valid || bus.m_ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_PAYLOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: footer bytes advance only when the output slot is free
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PAYLOAD: if (w_s_accept && bus.s_last_i) w_state_next = ST_CRC_LO;
            ST_CRC_LO:  if (w_out_free)                 w_state_next = ST_CRC_HI;
            ST_CRC_HI:  if (w_out_free)                 w_state_next = ST_PAYLOAD;
            default:                                    w_state_next = ST_PAYLOAD;
        endcase
    end

    // Output decode: ready, output-register load and CRC update per state
    always_comb begin
        w_s_ready   = 1'b0;
        w_s_accept  = 1'b0;
        w_load      = 1'b0;
        w_load_data = r_m_data;
        w_load_last = 1'b0;
        w_crc_next  = r_crc;
        case (r_state)
            ST_PAYLOAD: begin
                w_s_ready = w_out_free;
                if (w_out_free && bus.s_valid_i) begin
                    w_s_accept  = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = bus.s_data_i;
                    w_crc_next  = crc_step8(r_crc, bus.s_data_i);
                end
            end
            ST_CRC_LO: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_crc[7:0];
                end
            end
            ST_CRC_HI: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_crc[15:8];
                    w_load_last = 1'b1;
                    w_crc_next  = SEED;
                end
            end
            default: begin
                w_s_ready = 1'b0;
            end
        endcase
    end

    // Output register and running CRC; output holds until downstream takes it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_crc     <= SEED;
        end else begin
            if (w_load) begin
                r_m_data  <= w_load_data;
                r_m_valid <= 1'b1;
                r_m_last  <= w_load_last;
            end else if (bus.m_ready_i) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            r_crc <= w_crc_next;
        end
    end

    assign bus.s_ready_o = w_s_ready;
    assign bus.m_data_o  = r_m_data;
    assign bus.m_valid_o = r_m_valid;
    assign bus.m_last_o  = r_m_last;
    assign crc_o         = r_crc;

endmodule
